dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Load/store unit for the data-memory port: accepts one RV32 load or store request at a time from the memory pipeline stage, drives the byte-write-enable data SRAM (1-cycle registered read, per-byte write enables, output forced to 0 when not enabled), and returns a formatted, sign/zero-extended response. It sits between the execute/memory stage and the data SRAM as the initiator on that interface.

## Interface
Parameters:
- ADDR_WIDTH, 8: SRAM word-address width; must equal the SRAM's ADDR_WIDTH.
- DATA_WIDTH, 32: fixed at 32; other values unsupported.

Ports:
- clk  in  1  clock; everything samples on posedge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 size/sign code.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal funct3.
- sram_en  out  1  SRAM enable.
- sram_we  out  4  SRAM byte write enables.
- sram_addr  out  ADDR_WIDTH  SRAM word address.
- sram_din  out  32  SRAM write data.
- sram_dout  in  32  SRAM read data.

## Operation
- States: IDLE, ACCESS, CAPTURE, RESP.
- IDLE: req_ready=1. On req_valid, latch request. Legal → ACCESS. Illegal → RESP, resp_err=1, no SRAM access.
- Legal codes: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW. Other codes → illegal.
- Alignment: halfword needs addr[0]=0; word needs addr[1:0]=0. Violation → illegal.
- sram_addr = req_addr[ADDR_WIDTH+1:2]. Higher address bits are ignored, so addresses wrap modulo SRAM size.
- Store lanes:
  - SB: sram_we = 4'b0001<<addr[1:0], sram_din = {4{wdata[7:0]}}.
  - SH: sram_we = addr[1] ? 4'b1100 : 4'b0011, sram_din = {2{wdata[15:0]}}.
  - SW: sram_we = 4'b1111, sram_din = wdata.
- Loads: sram_we = 0.
- ACCESS: sram_en=1 with registered addr/we/din for exactly one cycle → CAPTURE.
- CAPTURE: sram_en=0. Sample sram_dout.
  - Select byte addr[1:0] or halfword addr[1].
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
  - Register the result into resp_rdata (0 for stores) → RESP.
- RESP: resp_valid=1 and resp_rdata/resp_err stable until resp_ready. On the handshake edge → IDLE.
- A new request is accepted no earlier than the cycle after resp handshake; there is no back-to-back overlap.

## Timing
- Reset values: req_ready=0 while rst is high, 1 the first cycle after. All other outputs 0. State IDLE.
- rst mid-operation clears sram_en/sram_we immediately (asynchronous) and drops any in-flight request without a response.
- Legal access: accept edge T0; sram_en high in cycle T0+1; data captured at edge T0+2; resp_valid high from T0+2 (3-cycle latency accept→resp_valid).
- Illegal access: resp_valid high in cycle after accept (1-cycle latency); sram_en never asserted.
- sram_en is a single-cycle pulse per legal request. The SRAM output is valid only in CAPTURE, because the SRAM zeroes its output when not enabled.
- resp_ready held low: response holds indefinitely; no further SRAM activity.

## Structure
- Package dmem_lsu_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum, lane-mask function.
- Sub-module dmem_load_extract (combinational): sram_dout, addr[1:0], funct3 → 32-bit extended load value. Instantiated once in the CAPTURE path.

## Test plan
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → sram_we=1111 at word 4; load resp_rdata=0xDEADBEEF, err=0, resp_valid 3 cycles after accept.
- SB 0x13 data 0x000000A5, then LB 0x13 and LBU 0x13 → we=1000; LB=0xFFFFFFA5, LBU=0x000000A5; other bytes of word 4 unchanged.
- SH 0x22 data 0x8001, then LH 0x22 and LHU 0x22 → we=1100; LH=0xFFFF8001, LHU=0x00008001.
- LW 0x05, LH 0x03, funct3=011 → resp_err=1, rdata=0, resp_valid 1 cycle after accept, sram_en never high.
- LW with resp_ready low for 5 cycles → resp_valid and rdata stable throughout, req_ready=0, no sram_en; IDLE after handshake.
- rst asserted during ACCESS → sram_en/sram_we drop in the same cycle, no response issued, next request completes normally.

Source files
------------

// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
// Contents: funct3 size/sign codes, LSU state enum, store lane helpers,
// request legality check.
package dmem_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  // Byte write enables for a store of the given size at the given byte offset.
  function automatic logic [3:0] lane_mask(input logic [2:0] funct3,
                                           input logic [1:0] offset);
    logic [3:0] mask;
    mask = 4'b0000;
    case (funct3)
      F3_B:    mask = 4'b0001 << offset;
      F3_H:    mask = offset[1] ? 4'b1100 : 4'b0011;
      F3_W:    mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  // Store data replicated across all lanes so the write mask alone picks
  // the destination bytes.
  function automatic logic [31:0] store_lanes(input logic [2:0]  funct3,
                                              input logic [31:0] wdata);
    logic [31:0] lanes;
    lanes = wdata;
    case (funct3)
      F3_B:    lanes = {4{wdata[7:0]}};
      F3_H:    lanes = {2{wdata[15:0]}};
      default: lanes = wdata;
    endcase
    return lanes;
  endfunction

  // A request is legal when the code exists for its direction and the
  // address is naturally aligned for the access size.
  function automatic logic req_legal(input logic       we,
                                     input logic [2:0] funct3,
                                     input logic [1:0] offset);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~offset[0];
      F3_W:    ok = (offset == 2'b00);
      F3_BU:   ok = ~we;
      F3_HU:   ok = ~we & ~offset[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_load_extract.sv
// Selects the addressed byte/halfword of an SRAM read word and extends it.
// Latency: combinational.
// Backpressure: none.
// Ports: dout (SRAM word), offset (byte address bits [1:0]), funct3 (size/sign
// code), value (right-aligned, sign- or zero-extended result).
module dmem_load_extract
  import dmem_lsu_pkg::*;
(
  input  logic [31:0] dout,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (offset)
      2'd0:    byte_sel = dout[7:0];
      2'd1:    byte_sel = dout[15:8];
      2'd2:    byte_sel = dout[23:16];
      default: byte_sel = dout[31:24];
    endcase
    half_sel = offset[1] ? dout[31:16] : dout[15:0];
  end

  always_comb begin
    value = dout;
    case (funct3)
      F3_B:    value = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   value = {24'h000000, byte_sel};
      F3_H:    value = {{16{half_sel[15]}}, half_sel};
      F3_HU:   value = {16'h0000, half_sel};
      default: value = dout;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit driving a byte-enable data SRAM with a 1-cycle registered read.
// Latency: legal access 3 cycles accept->resp_valid, illegal access 1 cycle.
// Backpressure: one request in flight; req_ready only in IDLE, response held until resp_ready.
// Ports: clk/rst; req_* request channel (valid/ready); resp_* response channel
// (valid/ready); sram_* SRAM initiator port (en, byte we, word addr, din, dout).
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  sram_en,
  output logic [3:0]            sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  state_t state, state_next;

  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [1:0]            offset_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            mask_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic [DATA_WIDTH-1:0] load_value;
  logic                  legal;
  logic                  accept;
  logic                  unused_addr;

  // Bits above the SRAM word index are deliberately dropped: addresses wrap.
  assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];

  assign legal  = req_legal(req_we, req_funct3, req_addr[1:0]);
  assign accept = (state == IDLE) && req_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // sram_en/sram_we are decoded from state so an asynchronous reset removes
  // them in the same cycle.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    sram_en    = 1'b0;
    sram_we    = 4'b0000;
    case (state)
      IDLE: begin
        req_ready = ~rst;
        if (req_valid) state_next = legal ? ACCESS : RESP;
      end
      ACCESS: begin
        sram_en    = 1'b1;
        sram_we    = mask_q;
        state_next = CAPTURE;
      end
      CAPTURE: begin
        state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      offset_q   <= 2'b00;
      addr_q     <= '0;
      mask_q     <= 4'b0000;
      din_q      <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (accept) begin
      we_q       <= req_we;
      funct3_q   <= req_funct3;
      offset_q   <= req_addr[1:0];
      addr_q     <= req_addr[ADDR_WIDTH+1:2];
      mask_q     <= (req_we && legal) ? lane_mask(req_funct3, req_addr[1:0]) : 4'b0000;
      din_q      <= req_we ? store_lanes(req_funct3, req_wdata) : '0;
      resp_rdata <= '0;
      resp_err   <= ~legal;
    end else if (state == CAPTURE) begin
      // sram_dout is only meaningful here: the SRAM zeroes it when idle.
      resp_rdata <= we_q ? '0 : load_value;
    end
  end

  assign sram_addr = addr_q;
  assign sram_din  = din_q;

  dmem_load_extract u_extract (
    .dout   (sram_dout),
    .offset (offset_q),
    .funct3 (funct3_q),
    .value  (load_value)
  );

endmodule

// File: tb/tb_dmem_lsu.sv
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [7:0]  sram_addr;
  logic [31:0] sram_din, sram_dout;
  logic        mem_clear;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_lsu #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );

  // SRAM: registered read, byte write enables, output zero when not enabled.
  logic [31:0] sram_mem [0:255];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) sram_mem[i] <= 32'h0;
      sram_dout <= 32'h0;
    end else if (sram_en) begin
      for (int b = 0; b < 4; b++)
        if (sram_we[b]) sram_mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
      sram_dout <= sram_mem[sram_addr];
    end else begin
      sram_dout <= 32'h0;
    end
  end

  // Reference model: flat byte memory of the 1 KiB the SRAM covers.
  logic [7:0]  ref_mem [0:1023];
  logic        exp_legal;
  logic [3:0]  exp_we;
  logic [7:0]  exp_addr;
  logic [31:0] exp_din, exp_rdata;

  // Observations from the last request.
  int          obs_lat, obs_en, obs_unstable;
  logic [3:0]  obs_we;
  logic [7:0]  obs_addr;
  logic [31:0] obs_din, obs_rdata;
  logic        obs_err, obs_idle;

  task automatic model_apply(input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata);
    int size, off, idx;
    logic [31:0] v;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    off  = int'(addr[1:0]);
    idx  = int'(addr[9:0]);
    if (we) exp_legal = (f3 <= 3'd2);
    else    exp_legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    if ((off % size) != 0) exp_legal = 1'b0;
    exp_we = 4'b0; exp_din = 32'h0; exp_rdata = 32'h0;
    exp_addr = addr[9:2];
    if (exp_legal && we) begin
      for (int k = 0; k < size; k++) begin
        exp_we[off+k] = 1'b1;
        ref_mem[idx+k] = wdata[8*k +: 8];
      end
      for (int k = 0; k < 4; k++) exp_din[8*k +: 8] = wdata[8*(k % size) +: 8];
    end else if (exp_legal) begin
      v = 32'h0;
      for (int k = 0; k < size; k++) v = v | (32'(ref_mem[idx+k]) << (8*k));
      if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8*size)) - 32'd1);
      exp_rdata = v;
    end
  endtask

  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input int stall);
    int n;
    model_apply(we, f3, addr, wdata);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (n >= 20) begin
      errors++;
      $display("FAIL req_ready_wait: req_ready=%b after %0d cycles, required 1", req_ready, n);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    obs_lat = 0; obs_en = 0; obs_we = 4'b0; obs_addr = 8'h0; obs_din = 32'h0;
    while (obs_lat < 20) begin
      @(negedge clk);
      obs_lat++;
      if (sram_en) begin
        obs_en++; obs_we = sram_we; obs_addr = sram_addr; obs_din = sram_din;
      end
      if (resp_valid) break;
    end
    obs_rdata = resp_rdata; obs_err = resp_err; obs_unstable = 0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_rdata !== obs_rdata || resp_err !== obs_err ||
          req_ready !== 1'b0 || sram_en !== 1'b0) obs_unstable++;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    obs_idle = (req_ready === 1'b1) && (resp_valid === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_clear = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = 32'h0;
    req_wdata = 32'h0; resp_ready = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_err, sram_en} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: ready/valid/err/en=%b required 0000",
               {req_ready, resp_valid, resp_err, sram_en});
    end
    checks++;
    if (sram_we !== 4'b0 || sram_addr !== 8'h0 || sram_din !== 32'h0 || resp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: we=%h addr=%h din=%h rdata=%h required all 0",
               sram_we, sram_addr, sram_din, resp_rdata);
    end
    rst = 1'b0; mem_clear = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: req_ready=%b required 1", req_ready);
    end
  endtask

  task automatic test_word();
    run_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0);
    checks++;
    if (obs_we !== 4'b1111 || obs_addr !== 8'd4 || obs_din !== 32'hDEADBEEF || obs_en !== 1) begin
      errors++;
      $display("FAIL sw_port: we=%b addr=%0d din=%h en_cycles=%0d required 1111/4/deadbeef/1",
               obs_we, obs_addr, obs_din, obs_en);
    end
    checks++;
    if (obs_lat !== 3 || obs_err !== 1'b0 || obs_rdata !== 32'h0 || !obs_idle) begin
      errors++;
      $display("FAIL sw_resp: lat=%0d err=%b rdata=%h idle=%b required 3/0/0/1",
               obs_lat, obs_err, obs_rdata, obs_idle);
    end
    run_req(1'b0, 3'b010, 32'h10, 32'h0, 0);
    checks++;
    if (obs_rdata !== 32'hDEADBEEF || obs_err !== 1'b0 || obs_lat !== 3 || obs_we !== 4'b0) begin
      errors++;
      $display("FAIL lw_resp: rdata=%h err=%b lat=%0d we=%b required deadbeef/0/3/0000",
               obs_rdata, obs_err, obs_lat, obs_we);
    end
  endtask

  task automatic test_byte_half();
    run_req(1'b1, 3'b000, 32'h13, 32'h000000A5, 0);
    checks++;
    if (obs_we !== 4'b1000 || obs_din !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL sb_port: we=%b din=%h required 1000/a5a5a5a5", obs_we, obs_din);
    end
    run_req(1'b0, 3'b000, 32'h13, 32'h0, 0);
    checks++;
    if (obs_rdata !== 32'hFFFFFFA5) begin
      errors++;
      $display("FAIL lb: rdata=%h required ffffffa5", obs_rdata);
    end
    run_req(1'b0, 3'b100, 32'h13, 32'h0, 0);
    checks++;
    if (obs_rdata !== 32'h000000A5) begin
      errors++;
      $display("FAIL lbu: rdata=%h required 000000a5", obs_rdata);
    end
    run_req(1'b0, 3'b010, 32'h10, 32'h0, 0);
    checks++;
    if (obs_rdata !== 32'hA5ADBEEF) begin
      errors++;
      $display("FAIL sb_other_bytes: rdata=%h required a5adbeef", obs_rdata);
    end
    run_req(1'b1, 3'b001, 32'h22, 32'h00008001, 0);
    checks++;
    if (obs_we !== 4'b1100 || obs_addr !== 8'd8 || obs_din !== 32'h80018001) begin
      errors++;
      $display("FAIL sh_port: we=%b addr=%0d din=%h required 1100/8/80018001",
               obs_we, obs_addr, obs_din);
    end
    run_req(1'b0, 3'b001, 32'h22, 32'h0, 0);
    checks++;
    if (obs_rdata !== 32'hFFFF8001) begin
      errors++;
      $display("FAIL lh: rdata=%h required ffff8001", obs_rdata);
    end
    run_req(1'b0, 3'b101, 32'h22, 32'h0, 0);
    checks++;
    if (obs_rdata !== 32'h00008001) begin
      errors++;
      $display("FAIL lhu: rdata=%h required 00008001", obs_rdata);
    end
  endtask

  task automatic test_illegal();
    logic        t_we   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0]  t_f3   [5] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b001};
    logic [31:0] t_addr [5] = '{32'h05, 32'h03, 32'h40, 32'h44, 32'h21};
    for (int i = 0; i < 5; i++) begin
      run_req(t_we[i], t_f3[i], t_addr[i], 32'hFFFF_FFFF, 0);
      checks++;
      if (obs_err !== 1'b1 || obs_rdata !== 32'h0 || obs_lat !== 1 || obs_en !== 0 || !obs_idle) begin
        errors++;
        $display("FAIL illegal_%0d: err=%b rdata=%h lat=%0d en_cycles=%0d idle=%b required 1/0/1/0/1",
                 i, obs_err, obs_rdata, obs_lat, obs_en, obs_idle);
      end
    end
  endtask

  task automatic test_stall();
    run_req(1'b0, 3'b010, 32'h10, 32'h0, 5);
    checks++;
    if (obs_unstable !== 0 || obs_rdata !== 32'hA5ADBEEF || obs_en !== 1 || !obs_idle) begin
      errors++;
      $display("FAIL stall: unstable=%0d rdata=%h en_cycles=%0d idle=%b required 0/a5adbeef/1/1",
               obs_unstable, obs_rdata, obs_en, obs_idle);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h10; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (sram_en !== 1'b1 || sram_we !== 4'b1111) begin
      errors++;
      $display("FAIL mid_access: en=%b we=%b required 1/1111", sram_en, sram_we);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (sram_en !== 1'b0 || sram_we !== 4'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async: en=%b we=%b ready=%b required 0/0000/0",
               sram_en, sram_we, req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || sram_en !== 1'b0 || req_ready !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_reset_quiet: %0d bad cycles, required 0", bad);
    end
    // The aborted store never reached the SRAM, so the old word remains.
    run_req(1'b0, 3'b010, 32'h10, 32'h0, 0);
    checks++;
    if (obs_rdata !== 32'hA5ADBEEF || obs_rdata !== exp_rdata || obs_lat !== 3) begin
      errors++;
      $display("FAIL mid_reset_after: rdata=%h lat=%0d required a5adbeef/3", obs_rdata, obs_lat);
    end
  endtask

  task automatic test_random();
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;
    int          size;
    for (int n = 0; n < 150; n++) begin
      we    = 1'($urandom_range(0, 1));
      f3    = 3'($urandom_range(0, 7));
      addr  = $urandom();
      wdata = $urandom();
      size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      if ($urandom_range(0, 3) != 0) addr = addr & ~(32'(size) - 32'd1);
      run_req(we, f3, addr, wdata, $urandom_range(0, 2));
      checks++;
      if (obs_err !== !exp_legal || obs_rdata !== exp_rdata || !obs_idle || obs_unstable != 0) begin
        errors++;
        $display("FAIL rand_%0d_resp: we=%b f3=%b addr=%h err=%b rdata=%h required err=%b rdata=%h",
                 n, we, f3, addr, obs_err, obs_rdata, !exp_legal, exp_rdata);
      end
      checks++;
      if (obs_lat !== (exp_legal ? 3 : 1) || obs_en !== (exp_legal ? 1 : 0)) begin
        errors++;
        $display("FAIL rand_%0d_timing: lat=%0d en_cycles=%0d required %0d/%0d",
                 n, obs_lat, obs_en, exp_legal ? 3 : 1, exp_legal ? 1 : 0);
      end
      if (exp_legal) begin
        checks++;
        if (obs_we !== exp_we || obs_addr !== exp_addr || (we && obs_din !== exp_din)) begin
          errors++;
          $display("FAIL rand_%0d_port: we=%b addr=%h din=%h required %b/%h/%h",
                   n, obs_we, obs_addr, obs_din, exp_we, exp_addr, exp_din);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_illegal();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
